enc_64b: RTL and testbench
==========================

# enc_64b

Sequential 64-to-6 bit-scan encoder, the inverse of the 6-to-64 one-hot decoder used in the same datapath. It captures a 64-bit vector on `init_i` and emits the 6-bit index of every set bit, one per clock, in ascending order. `done_o` marks the end of each scan, and `cnt_o` reports the number of indices emitted. Used to turn request/occupancy bitmaps back into slot numbers for downstream control logic.

## Interface
- `OUT_REG`, default `1'b1`: 1 adds one output register stage to `valid_o`/`data_o`/`last_o`/`done_o`/`cnt_o`; 0 drives them directly from the scan state.
- `clk_i`  input  1  clock; all state on rising edge.
- `rst_n_i`  input  1  reset; one clock, asynchronous, active-low.
- `init_i`  input  1  start request; sampled only when `busy_o`=0.
- `data_i`  input  64  vector to scan; captured with an accepted `init_i`.
- `busy_o`  output  1  scan in progress; `init_i` ignored while high.
- `valid_o`  output  1  `data_o` carries a valid index this cycle.
- `data_o`  output  6  bit index (0..63); 0 when `valid_o`=0.
- `last_o`  output  1  current index is the highest set bit; 0 when `valid_o`=0.
- `done_o`  output  1  one-cycle pulse on the final cycle of a scan.
- `cnt_o`  output  7  indices emitted in the current/last scan (0..64).

## Operation
- States:
  - IDLE: `busy_o`=0.
  - SCAN: working mask register `mask_r[63:0]`.
- IDLE & `init_i`=1: `mask_r` <= `data_i`, internal count <= 0, go to SCAN. `init_i` is ignored in SCAN.
- Each SCAN cycle performs a two-level lowest-set-bit encode:
  - Group-nonzero flags for the 8 bytes select the lowest nonzero byte: `idx[5:3]`.
  - A 3-bit priority encode within that byte gives `idx[2:0]`.
- SCAN with `mask_r` != 0:
  - Emit `valid_o`=1 and `data_o`=idx.
  - Clear bit idx in `mask_r` and increment the count.
  - `last_o`=1 when `mask_r` has exactly one bit set.
- Scan end:
  - When `last_o`=1: `done_o`=1 in the same cycle, next state IDLE.
  - SCAN with `mask_r`=0 (only possible for zero input): `done_o`=1, `valid_o`=0, `cnt_o`=0, next state IDLE.
- `cnt_o` width rule: 7 bits, counts the emitted index including the current one (1st index shows 1). Saturation is unnecessary; max 64.
- `cnt_o` reset and hold: cleared on accepted init; holds its final value in IDLE until the next accepted init.
- Indices are strictly ascending, with no duplicates or gaps relative to the set bits of `data_i`.
- Reset mid-scan: all state cleared, IDLE, `mask_r`=0, no `done_o` pulse.

## Timing
- Reset values: `busy_o`=0, `valid_o`=0, `data_o`=0, `last_o`=0, `done_o`=0, `cnt_o`=0, `mask_r`=0, output register=0.
- `OUT_REG`=0 timing, with `init_i` accepted at edge E0:
  - First index appears in the cycle after E0.
  - An input with N set bits produces indices in cycles 1..N; `done_o` is in cycle N.
  - Zero input: `done_o` in cycle 1.
- `OUT_REG`=1 timing:
  - Every output listed above is delayed by exactly one cycle.
  - Throughput is unchanged: 1 index per cycle, no bubbles.
- `busy_o` is never registered by `OUT_REG`. It rises the cycle after the accepted init and stays high through the cycle in which `done_o` is visible at the port (N cycles for `OUT_REG`=0, N+1 for `OUT_REG`=1, zero input counts as N=1). It is low the following cycle.
- A new init is accepted on the first edge with `busy_o`=0. Back-to-back scans therefore have a minimum one-cycle gap after `done_o`.
- `init_i` held high continuously: the block restarts at the first IDLE edge, capturing the current `data_i`.
- `valid_o`, `last_o` and `done_o` are pulses. No backpressure; the consumer must take every index.

## Test plan
- `OUT_REG`=0, `data_i`=64'h1 -> one cycle: `valid_o`=1, `data_o`=0, `last_o`=1, `done_o`=1, `cnt_o`=1; `busy_o` low the next cycle.
- `data_i`=64'h8000_0000_0000_0101 -> `data_o` 0, 8, 63 on consecutive cycles; `last_o` and `done_o` only with 63; `cnt_o` ends at 3.
- `data_i`=all ones -> 64 consecutive valid cycles, `data_o`=0..63; final `cnt_o`=64 (7'h40).
- `data_i`=0 -> `valid_o` never high; `done_o` one cycle after init; `cnt_o`=0.
- Pulse `init_i` with 64'hF0 mid-scan -> ignored; the original scan completes unchanged. Assert `rst_n_i` low mid-scan -> all outputs 0 asynchronously; no `done_o`; a fresh scan after release is correct.
- `OUT_REG`=1, `data_i`=64'h0000_0100_0000_0004 -> indices 2, 40, each one cycle later than in `OUT_REG`=0; `busy_o` covers the delayed `done_o`.

Source files
------------

// File: rtl/enc_64b.sv
// Sequential 64-to-6 bit-scan encoder: captures a bitmap on init_i and emits the
// index of every set bit, lowest first, one per clock, with an optional output register.
module enc_64b #(
  parameter logic OUT_REG = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        init_i,
  input  logic [63:0] data_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [5:0]  data_o,
  output logic        last_o,
  output logic        done_o,
  output logic [6:0]  cnt_o
);

  localparam int DATA_W = 64;
  localparam int IDX_W  = 6;
  localparam int CNT_W  = 7;

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t              state_r;
  logic [DATA_W-1:0]   mask_r;
  logic [CNT_W-1:0]    cnt_r;

  // Lowest-set-bit priority encode of one byte; returns 0 for an all-zero byte.
  function automatic logic [2:0] pri8(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  logic [7:0]        grp_nz;
  logic [2:0]        idx_hi;
  logic [2:0]        idx_lo;
  logic [7:0]        sel_byte;
  logic [IDX_W-1:0]  idx;
  logic              mask_nz;
  logic              single;
  logic              scan;
  logic              accept;

  logic              vld_p0;
  logic [IDX_W-1:0]  data_p0;
  logic              last_p0;
  logic              done_p0;
  logic [CNT_W-1:0]  cnt_p0;

  // Stage p0: two-level encode straight from the scan state
  always_comb begin
    for (int b = 0; b < 8; b++) begin
      grp_nz[b] = |mask_r[b*8 +: 8];
    end
    idx_hi   = pri8(grp_nz);
    sel_byte = mask_r[{idx_hi, 3'b000} +: 8];
    idx_lo   = pri8(sel_byte);
    idx      = {idx_hi, idx_lo};
    mask_nz  = |mask_r;
    single   = mask_nz && ((mask_r & (mask_r - 64'd1)) == '0);
    scan     = (state_r == S_SCAN);
    vld_p0   = scan && mask_nz;
    data_p0  = vld_p0 ? idx : '0;
    last_p0  = vld_p0 && single;
    // A zero capture ends the scan on its first cycle with nothing emitted.
    done_p0  = scan && (single || !mask_nz);
    cnt_p0   = cnt_r + {{(CNT_W-1){1'b0}}, vld_p0};
  end

  assign accept = init_i && !busy_o;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= S_IDLE;
      mask_r  <= '0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept) begin
            state_r <= S_SCAN;
            mask_r  <= data_i;
            cnt_r   <= '0;
          end
        end
        S_SCAN: begin
          if (vld_p0) mask_r <= mask_r & ~(64'd1 << idx);
          cnt_r <= cnt_p0;
          if (done_p0) state_r <= S_IDLE;
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic              vld_p1;
      logic [IDX_W-1:0]  data_p1;
      logic              last_p1;
      logic              done_p1;
      logic [CNT_W-1:0]  cnt_p1;

      // Stage p1: output register; busy stays up until the delayed done has shown
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          vld_p1  <= 1'b0;
          data_p1 <= '0;
          last_p1 <= 1'b0;
          done_p1 <= 1'b0;
          cnt_p1  <= '0;
        end else begin
          vld_p1  <= vld_p0;
          data_p1 <= data_p0;
          last_p1 <= last_p0;
          done_p1 <= done_p0;
          cnt_p1  <= cnt_p0;
        end
      end

      assign busy_o  = scan || done_p1;
      assign valid_o = vld_p1;
      assign data_o  = data_p1;
      assign last_o  = last_p1;
      assign done_o  = done_p1;
      assign cnt_o   = cnt_p1;
    end else begin : g_out_comb
      assign busy_o  = scan;
      assign valid_o = vld_p0;
      assign data_o  = data_p0;
      assign last_o  = last_p0;
      assign done_o  = done_p0;
      assign cnt_o   = cnt_p0;
    end
  endgenerate

endmodule

// File: tb/tb_enc_64b.sv
// Bench for enc_64b: both OUT_REG variants run side by side on shared stimulus and
// are compared cycle by cycle against a set-bit list model of the scan.
module tb_enc_64b;

  logic        clk_i   = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        init_i  = 1'b0;
  logic [63:0] data_i  = '0;

  logic       busy_a, valid_a, last_a, done_a;
  logic [5:0] data_a;
  logic [6:0] cnt_a;
  logic       busy_b, valid_b, last_b, done_b;
  logic [5:0] data_b;
  logic [6:0] cnt_b;

  enc_64b #(.OUT_REG(1'b0)) u_dut_a (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .init_i(init_i), .data_i(data_i),
    .busy_o(busy_a), .valid_o(valid_a), .data_o(data_a), .last_o(last_a),
    .done_o(done_a), .cnt_o(cnt_a)
  );

  enc_64b #(.OUT_REG(1'b1)) u_dut_b (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .init_i(init_i), .data_i(data_i),
    .busy_o(busy_b), .valid_o(valid_b), .data_o(data_b), .last_o(last_b),
    .done_o(done_b), .cnt_o(cnt_b)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int errors   = 0;
  int prev_cnt = 0;
  int exp_n    = 0;
  int exp_idx [64];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected unregistered outputs k cycles after the accepting edge (k=0: the init cycle).
  task automatic exp_out(input int k, output logic v, output logic [5:0] d,
                         output logic l, output logic dn, output logic [6:0] c);
    int nn;
    nn = (exp_n == 0) ? 1 : exp_n;
    v = 1'b0; d = '0; l = 1'b0; dn = 1'b0; c = 7'(prev_cnt);
    if (k >= 1 && k <= nn) begin
      v  = (exp_n > 0);
      d  = (exp_n > 0) ? 6'(exp_idx[k-1]) : 6'd0;
      l  = (exp_n > 0) && (k == exp_n);
      dn = (k == nn);
      c  = (exp_n > 0) ? 7'(k) : 7'd0;
    end else if (k > nn) begin
      c = 7'(exp_n);
    end
  endtask

  task automatic check_cycle(input int k);
    logic v, l, dn;
    logic [5:0] d;
    logic [6:0] c;
    int nn;
    nn = (exp_n == 0) ? 1 : exp_n;
    exp_out(k, v, d, l, dn, c);
    chk($sformatf("a.busy k%0d", k),  busy_a,  (k >= 1 && k <= nn));
    chk($sformatf("a.valid k%0d", k), valid_a, v);
    chk($sformatf("a.data k%0d", k),  data_a,  d);
    chk($sformatf("a.last k%0d", k),  last_a,  l);
    chk($sformatf("a.done k%0d", k),  done_a,  dn);
    chk($sformatf("a.cnt k%0d", k),   cnt_a,   c);
    exp_out(k - 1, v, d, l, dn, c);
    chk($sformatf("b.busy k%0d", k),  busy_b,  (k >= 1 && k <= nn + 1));
    chk($sformatf("b.valid k%0d", k), valid_b, v);
    chk($sformatf("b.data k%0d", k),  data_b,  d);
    chk($sformatf("b.last k%0d", k),  last_b,  l);
    chk($sformatf("b.done k%0d", k),  done_b,  dn);
    chk($sformatf("b.cnt k%0d", k),   cnt_b,   c);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy_a || busy_b) && t < 300) begin
      @(negedge clk_i);
      t++;
    end
    if (busy_a || busy_b) chk("idle_timeout", {busy_a, busy_b}, 2'b00);
  endtask

  task automatic run_scan(input logic [63:0] d, input bit mid_init);
    int nn;
    wait_idle();
    exp_n = 0;
    for (int i = 0; i < 64; i++) begin
      if (d[i]) begin
        exp_idx[exp_n] = i;
        exp_n++;
      end
    end
    nn = (exp_n == 0) ? 1 : exp_n;
    init_i = 1'b1;
    data_i = d;
    for (int k = 1; k <= nn + 2; k++) begin
      @(negedge clk_i);
      check_cycle(k);
      if (k == 1) begin
        init_i = mid_init;
        data_i = mid_init ? 64'hF0 : {$urandom, $urandom};
      end
      if (k == 2) init_i = 1'b0;
    end
    prev_cnt = exp_n;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " a.busy"}, busy_a, 0);   chk({tag, " b.busy"}, busy_b, 0);
    chk({tag, " a.valid"}, valid_a, 0); chk({tag, " b.valid"}, valid_b, 0);
    chk({tag, " a.data"}, data_a, 0);   chk({tag, " b.data"}, data_b, 0);
    chk({tag, " a.last"}, last_a, 0);   chk({tag, " b.last"}, last_b, 0);
    chk({tag, " a.done"}, done_a, 0);   chk({tag, " b.done"}, done_b, 0);
    chk({tag, " a.cnt"}, cnt_a, 0);     chk({tag, " b.cnt"}, cnt_b, 0);
  endtask

  task automatic reset_mid_scan();
    wait_idle();
    init_i = 1'b1;
    data_i = '1;
    @(negedge clk_i);
    init_i = 1'b0;
    repeat (4) @(negedge clk_i);
    #2 rst_n_i = 1'b0;
    #1 check_all_zero("rst_async");
    @(negedge clk_i);
    check_all_zero("rst_hold");
    rst_n_i  = 1'b1;
    prev_cnt = 0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [63:0] d;
    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    rst_n_i = 1'b1;
    @(negedge clk_i);

    run_scan(64'h1, 1'b0);
    run_scan(64'h8000_0000_0000_0101, 1'b0);
    run_scan('1, 1'b0);
    run_scan(64'h0, 1'b0);
    run_scan(64'h0000_0100_0000_0004, 1'b0);
    run_scan(64'hA5A5_0000_0000_1234, 1'b1);
    reset_mid_scan();
    run_scan(64'h8000_0000_0000_8001, 1'b0);

    for (int r = 0; r < 24; r++) begin
      d = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: ;
        1: d = d & {$urandom, $urandom};
        2: d = 64'd1 << $urandom_range(0, 63);
        default: d = d & {$urandom, $urandom} & {$urandom, $urandom};
      endcase
      run_scan(d, ($countones(d) >= 2) && ($urandom_range(0, 1) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
